// File: rtl/pe_sequencer.sv
// pe_sequencer: drives one PE through a full output pass.
// For every output byte: load LOAD_WORDS operand words, clear the MAC,
// step the MAC index, wait for the result, and write it to the result
// memory. After the last byte a single done pulse is issued.
//
// state   | meaning
// --------+-----------------------------------------------------------
// S_IDLE  | waiting for start; outputs quiet, addr holds last value
// S_LOAD  | in_ready high; one operand word accepted per in_valid cycle
// S_CLR   | one cycle of rstmac with cnt=0
// S_MAC   | MAC_STEPS cycles, cnt = 0 .. MAC_STEPS-1
// S_WAIT  | MAC_LAT cycles, cnt held at its last value
// S_WRITE | one cycle of enW at the current byte address
// S_DONE  | one cycle of done (busy still high)
module pe_sequencer #(
    parameter int M          = 127,
    parameter int L          = (M == 127) ? 3 : 5,
    parameter int LOAD_WORDS = (M + 1) / 32,
    parameter int MAC_STEPS  = 2 ** (L + 1),
    parameter int MAC_LAT    = 1,
    parameter int NOUT       = 172
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         start_i,
    input  logic         in_valid_i,
    output logic         in_ready_o,
    output logic         en_o,
    output logic         rstmac_o,
    output logic [L:0]   cnt_o,
    output logic         enw_o,
    output logic [7:0]   addr_o,
    output logic         done_o,
    output logic         busy_o
);

    localparam int CW   = L + 1;
    localparam int LDW  = (LOAD_WORDS > 1) ? $clog2(LOAD_WORDS) : 1;
    localparam int LATW = (MAC_LAT > 1) ? $clog2(MAC_LAT) : 1;

    localparam logic [LDW-1:0]  LOAD_LAST = LDW'(LOAD_WORDS - 1);
    localparam logic [CW-1:0]   MAC_LAST  = CW'(MAC_STEPS - 1);
    localparam logic [7:0]      ADDR_LAST = 8'(NOUT - 1);
    // WAIT runs as a down-counter ending at zero
    localparam logic [LATW-1:0] LAT_INIT  = LATW'((MAC_LAT > 0) ? (MAC_LAT - 1) : 0);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_CLR,
        S_MAC,
        S_WAIT,
        S_WRITE,
        S_DONE
    } state_t;

    state_t          state_q, state_d;
    logic [LDW-1:0]  load_q, load_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [LATW-1:0] lat_q, lat_d;
    logic [7:0]      addr_q, addr_d;

    logic in_ready_q, in_ready_d;
    logic rstmac_q, rstmac_d;
    logic enw_q, enw_d;
    logic done_q, done_d;
    logic busy_q, busy_d;

    // a word is consumed only when the registered ready meets upstream valid
    assign en_o = in_valid_i & in_ready_q;

    // next-state and counter updates
    always_comb begin
        state_d = state_q;
        load_d  = load_q;
        cnt_d   = cnt_q;
        lat_d   = lat_q;
        addr_d  = addr_q;

        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    state_d = S_LOAD;
                    addr_d  = '0;
                    load_d  = '0;
                end
            end
            S_LOAD: begin
                if (en_o) begin
                    if (load_q == LOAD_LAST) begin
                        load_d  = '0;
                        state_d = S_CLR;
                    end else begin
                        load_d = load_q + LDW'(1);
                    end
                end
            end
            S_CLR: begin
                state_d = S_MAC;
                cnt_d   = '0;
            end
            S_MAC: begin
                if (cnt_q == MAC_LAST) begin
                    if (MAC_LAT == 0) begin
                        state_d = S_WRITE;
                    end else begin
                        state_d = S_WAIT;
                        lat_d   = LAT_INIT;
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_WAIT: begin
                if (lat_q == '0) begin
                    state_d = S_WRITE;
                end else begin
                    lat_d = lat_q - LATW'(1);
                end
            end
            S_WRITE: begin
                if (addr_q == ADDR_LAST) begin
                    state_d = S_DONE;
                end else begin
                    addr_d  = addr_q + 8'd1;
                    state_d = S_LOAD;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // cnt is only meaningful from MAC through WRITE
        if (state_d == S_IDLE || state_d == S_LOAD ||
            state_d == S_CLR  || state_d == S_DONE) begin
            cnt_d = '0;
        end
    end

    // Moore outputs decoded from the upcoming state so they come straight off flops
    always_comb begin
        in_ready_d = (state_d == S_LOAD);
        rstmac_d   = (state_d == S_CLR);
        enw_d      = (state_d == S_WRITE);
        done_d     = (state_d == S_DONE);
        busy_d     = (state_d != S_IDLE);
    end

    // state, counters and registered outputs
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= S_IDLE;
            load_q     <= '0;
            cnt_q      <= '0;
            lat_q      <= '0;
            addr_q     <= '0;
            in_ready_q <= 1'b0;
            rstmac_q   <= 1'b0;
            enw_q      <= 1'b0;
            done_q     <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            load_q     <= load_d;
            cnt_q      <= cnt_d;
            lat_q      <= lat_d;
            addr_q     <= addr_d;
            in_ready_q <= in_ready_d;
            rstmac_q   <= rstmac_d;
            enw_q      <= enw_d;
            done_q     <= done_d;
            busy_q     <= busy_d;
        end
    end

    assign in_ready_o = in_ready_q;
    assign rstmac_o   = rstmac_q;
    assign cnt_o      = cnt_q;
    assign enw_o      = enw_q;
    assign addr_o     = addr_q;
    assign done_o     = done_q;
    assign busy_o     = busy_q;

endmodule
